// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//
// Central stall / flush / enable controller for the 5-stage MIPS pipeline.
// A single FSM combines the icache and dcache hits, the MEM-stage data
// request, the load-use hazard, the MEM-stage redirect and halt. It produces
// the enables and flushes of the four pipeline latches, the PC enable and
// select, the dcache request gate and the registered processor halt.
//
// The WAIT_D / WAIT_I states remember a hit that arrived before its partner:
// WAIT_D means the instruction fetch already hit and only the data access
// is outstanding; WAIT_I means the data access already hit and only the
// fetch is outstanding. The pipeline advances once both sides are satisfied.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN after halt is accepted (1..15)
//   STALL_W       width of the saturating stall-cycle counter
//
// Ports:
//   CLK           rising-edge clock
//   nRST          synchronous active-low reset
//   ihit          icache hit this cycle
//   dhit          dcache hit this cycle
//   dreq          MEM stage holds a load or store
//   load_use      ID instruction needs a load result still in EX
//   redirect      MEM stage resolved a mispredict, J/JAL or JR
//   halt_mem      halt instruction in MEM
//   en_fd/de/em/mw     pipeline latch enables
//   flush_fd/de/em     pipeline latch flushes (meaningful with the enable)
//   pc_en         PC update enable
//   pc_redirect   PC takes the MEM-stage target
//   dmem_req_en   gate on dmemREN/dmemWEN
//   halt          registered processor halt
//   stall_cnt     saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned STALL_W      = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               dreq,
    input  logic               load_use,
    input  logic               redirect,
    input  logic               halt_mem,
    output logic               en_fd,
    output logic               en_de,
    output logic               en_em,
    output logic               en_mw,
    output logic               flush_fd,
    output logic               flush_de,
    output logic               flush_em,
    output logic               pc_en,
    output logic               pc_redirect,
    output logic               dmem_req_en,
    output logic               halt,
    output logic [STALL_W-1:0] stall_cnt
);

    // Drain counter is wide enough for the full 1..15 range of DRAIN_CYCLES.
    localparam int unsigned            DRAIN_W    = 4;
    localparam logic [DRAIN_W-1:0]     DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [STALL_W-1:0]     STALL_MAX  = '1;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        WAIT_D = 3'd1,
        WAIT_I = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_cnt_next;

    logic active;     // FSM is in one of the hit-collecting states
    logic i_seen;     // fetch hit already captured
    logic d_seen;     // data hit already captured
    logic adv;        // whole pipeline may advance this cycle
    logic bubble;     // load-use bubble inserted this cycle
    logic stall_inc;  // this cycle counts as a stall

    // -------------------------------------------------------------------------
    // Hit bookkeeping and advance condition
    // -------------------------------------------------------------------------
    always_comb begin
        // Reset holds all combinational outputs quiet, as if in RUN with
        // every input low.
        active = nRST & ((state == RUN) | (state == WAIT_D) | (state == WAIT_I));
        i_seen = (state == WAIT_D);
        d_seen = (state == WAIT_I);

        // A captured hit stands in for the live one; with no data request
        // the dcache side is trivially satisfied.
        adv = active & (ihit | i_seen) & (~dreq | dhit | d_seen);

        // Once the dcache hit is captured the request is withdrawn so the
        // access is not repeated while the fetch side catches up.
        dmem_req_en = active & dreq & ~d_seen;
    end

    // -------------------------------------------------------------------------
    // Next-state and latch-control logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the case statement leaves it unassigned (no latches).
        next_state     = state;
        drain_cnt_next = drain_cnt;
        en_fd          = 1'b0;
        en_de          = 1'b0;
        en_em          = 1'b0;
        en_mw          = 1'b0;
        flush_fd       = 1'b0;
        flush_de       = 1'b0;
        flush_em       = 1'b0;
        pc_en          = 1'b0;
        pc_redirect    = 1'b0;
        bubble         = 1'b0;

        unique case (state)
            RUN, WAIT_D, WAIT_I: begin
                if (adv) begin
                    next_state = RUN;
                    if (halt_mem) begin
                        // Halt retires through WB; everything younger is
                        // squashed and the PC is frozen.
                        en_fd          = 1'b1;
                        en_de          = 1'b1;
                        en_em          = 1'b1;
                        en_mw          = 1'b1;
                        flush_fd       = 1'b1;
                        flush_de       = 1'b1;
                        flush_em       = 1'b1;
                        next_state     = DRAIN;
                        drain_cnt_next = DRAIN_LOAD;
                    end else if (redirect) begin
                        // Redirect squashes the wrong-path instructions and
                        // outranks load_use, whose consumer is being squashed.
                        en_fd       = 1'b1;
                        en_de       = 1'b1;
                        en_em       = 1'b1;
                        en_mw       = 1'b1;
                        flush_fd    = 1'b1;
                        flush_de    = 1'b1;
                        flush_em    = 1'b1;
                        pc_en       = 1'b1;
                        pc_redirect = 1'b1;
                    end else if (load_use) begin
                        // Hold IF/ID and the PC; inject a bubble into ID/EX
                        // while the load moves on to produce its result.
                        en_de    = 1'b1;
                        flush_de = 1'b1;
                        en_em    = 1'b1;
                        en_mw    = 1'b1;
                        bubble   = 1'b1;
                    end else begin
                        en_fd = 1'b1;
                        en_de = 1'b1;
                        en_em = 1'b1;
                        en_mw = 1'b1;
                        pc_en = 1'b1;
                    end
                end else if (state == RUN) begin
                    // Only an active data request makes an early hit worth
                    // remembering; a stray dhit with dreq low is ignored.
                    if (ihit & dreq & ~dhit) begin
                        next_state = WAIT_D;
                    end else if (dhit & dreq & ~ihit) begin
                        next_state = WAIT_I;
                    end
                end
            end

            DRAIN: begin
                // Only the MEM/WB latch moves so the halt and the
                // instructions ahead of it finish writing back.
                en_mw = 1'b1;
                if (drain_cnt == '0) begin
                    next_state = HALTED;
                end else begin
                    drain_cnt_next = drain_cnt - DRAIN_W'(1);
                end
            end

            HALTED: begin
                // Terminal: only reset leaves this state.
            end

            default: begin
                next_state = RUN;
            end
        endcase

        stall_inc = active & (~adv | bubble);
    end

    // -------------------------------------------------------------------------
    // State, drain counter, stall counter and halt registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments throughout so every register samples
        // the pre-edge values regardless of statement order.
        if (!nRST) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            halt      <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= drain_cnt_next;
            if (stall_inc && (stall_cnt != STALL_MAX)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            // Registered from next_state so halt rises on the first HALTED
            // cycle and stays high until reset.
            halt      <= (next_state == HALTED);
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
//
// Self-checking bench for pipeline_sequencer. Each scenario task walks a
// table of per-cycle input vectors; the expected outputs for every cycle are
// pushed to a scoreboard queue when the inputs are driven and popped and
// compared mid-cycle (falling edge), after the combinational outputs settle.
// Rows with chk=0 (reset cycles) carry no expectation.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

    localparam int STALL_W = 16;

    // Input vector: {nrst, ihit, dhit, dreq, load_use, redirect, halt_mem}
    typedef struct packed {
        logic nrst;
        logic ihit;
        logic dhit;
        logic dreq;
        logic load_use;
        logic redirect;
        logic halt_mem;
    } stim_t;

    // Control vector bit order:
    // {en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
    //  pc_en, pc_redirect, dmem_req_en, halt}
    typedef struct packed {
        logic               chk;
        logic [10:0]        ctl;
        logic [STALL_W-1:0] stall;
    } exp_t;

    localparam logic [10:0] C_IDLE   = {4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] C_REQ    = {4'b0000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [10:0] C_RUN    = {4'b1111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] C_RUN_D  = {4'b1111, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [10:0] C_LU     = {4'b0111, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] C_RED    = {4'b1111, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] C_HACC   = {4'b1111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] C_DRAIN  = {4'b0001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] C_HALTED = {4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};

    localparam exp_t SKIP = '0;

    logic               CLK;
    logic               nRST;
    logic               ihit, dhit, dreq, load_use, redirect, halt_mem;
    logic               en_fd, en_de, en_em, en_mw;
    logic               flush_fd, flush_de, flush_em;
    logic               pc_en, pc_redirect, dmem_req_en, halt;
    logic [STALL_W-1:0] stall_cnt;
    logic [10:0]        ctl_obs;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    pipeline_sequencer #(
        .DRAIN_CYCLES (2),
        .STALL_W      (STALL_W)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dreq        (dreq),
        .load_use    (load_use),
        .redirect    (redirect),
        .halt_mem    (halt_mem),
        .en_fd       (en_fd),
        .en_de       (en_de),
        .en_em       (en_em),
        .en_mw       (en_mw),
        .flush_fd    (flush_fd),
        .flush_de    (flush_de),
        .flush_em    (flush_em),
        .pc_en       (pc_en),
        .pc_redirect (pc_redirect),
        .dmem_req_en (dmem_req_en),
        .halt        (halt),
        .stall_cnt   (stall_cnt)
    );

    assign ctl_obs = {en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
                      pc_en, pc_redirect, dmem_req_en, halt};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t want(input logic [10:0] c, input int s);
        exp_t e;
        e.chk   = 1'b1;
        e.ctl   = c;
        e.stall = STALL_W'(s);
        return e;
    endfunction

    // Apply one cycle of inputs, record its expectation, move to mid-cycle.
    task automatic drive(input stim_t s, input exp_t e);
        nRST     = s.nrst;
        ihit     = s.ihit;
        dhit     = s.dhit;
        dreq     = s.dreq;
        load_use = s.load_use;
        redirect = s.redirect;
        halt_mem = s.halt_mem;
        sb.push_back(e);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        stim_t st[3] = '{7'b0_000_000, 7'b1_000_000, 7'b1_000_000};
        exp_t  ex[3] = '{SKIP, want(C_IDLE, 0), want(C_IDLE, 1)};
        exp_t  got;
        for (int i = 0; i < 3; i++) begin
            drive(st[i], ex[i]);
            got = sb.pop_front();
            if (got.chk) begin
                total++;
                if (ctl_obs !== got.ctl) begin
                    bad++;
                    $display("FAIL reset[%0d] ctl: got %b want %b", i, ctl_obs, got.ctl);
                end
                total++;
                if (stall_cnt !== got.stall) begin
                    bad++;
                    $display("FAIL reset[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, got.stall);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_run_stream();
        stim_t st[9] = '{7'b0_000_000, 7'b1_100_000, 7'b1_100_000, 7'b1_100_000,
                         7'b1_000_000, 7'b1_010_000, 7'b1_101_000, 7'b1_011_000,
                         7'b1_100_000};
        exp_t  ex[9] = '{SKIP, want(C_RUN, 0), want(C_RUN, 0), want(C_RUN, 0),
                         want(C_IDLE, 0), want(C_IDLE, 1), want(C_REQ, 2),
                         want(C_RUN_D, 3), want(C_RUN, 3)};
        exp_t  got;
        for (int i = 0; i < 9; i++) begin
            drive(st[i], ex[i]);
            got = sb.pop_front();
            if (got.chk) begin
                total++;
                if (ctl_obs !== got.ctl) begin
                    bad++;
                    $display("FAIL run_stream[%0d] ctl: got %b want %b", i, ctl_obs, got.ctl);
                end
                total++;
                if (stall_cnt !== got.stall) begin
                    bad++;
                    $display("FAIL run_stream[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, got.stall);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_wait_d();
        stim_t st[6] = '{7'b0_000_000, 7'b1_101_000, 7'b1_001_000, 7'b1_001_000,
                         7'b1_011_000, 7'b1_100_000};
        exp_t  ex[6] = '{SKIP, want(C_REQ, 0), want(C_REQ, 1), want(C_REQ, 2),
                         want(C_RUN_D, 3), want(C_RUN, 3)};
        exp_t  got;
        for (int i = 0; i < 6; i++) begin
            drive(st[i], ex[i]);
            got = sb.pop_front();
            if (got.chk) begin
                total++;
                if (ctl_obs !== got.ctl) begin
                    bad++;
                    $display("FAIL wait_d[%0d] ctl: got %b want %b", i, ctl_obs, got.ctl);
                end
                total++;
                if (stall_cnt !== got.stall) begin
                    bad++;
                    $display("FAIL wait_d[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, got.stall);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_wait_i();
        stim_t st[7] = '{7'b0_000_000, 7'b1_011_000, 7'b1_001_000, 7'b1_101_000,
                         7'b1_111_000, 7'b1_011_000, 7'b1_101_000};
        exp_t  ex[7] = '{SKIP, want(C_REQ, 0), want(C_IDLE, 1), want(C_RUN, 2),
                         want(C_RUN_D, 2), want(C_REQ, 2), want(C_RUN, 3)};
        exp_t  got;
        for (int i = 0; i < 7; i++) begin
            drive(st[i], ex[i]);
            got = sb.pop_front();
            if (got.chk) begin
                total++;
                if (ctl_obs !== got.ctl) begin
                    bad++;
                    $display("FAIL wait_i[%0d] ctl: got %b want %b", i, ctl_obs, got.ctl);
                end
                total++;
                if (stall_cnt !== got.stall) begin
                    bad++;
                    $display("FAIL wait_i[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, got.stall);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_hazards();
        stim_t st[7] = '{7'b0_000_000, 7'b1_100_100, 7'b1_100_110, 7'b1_100_010,
                         7'b1_100_000, 7'b1_000_100, 7'b1_100_000};
        exp_t  ex[7] = '{SKIP, want(C_LU, 0), want(C_RED, 1), want(C_RED, 1),
                         want(C_RUN, 1), want(C_IDLE, 1), want(C_RUN, 2)};
        exp_t  got;
        for (int i = 0; i < 7; i++) begin
            drive(st[i], ex[i]);
            got = sb.pop_front();
            if (got.chk) begin
                total++;
                if (ctl_obs !== got.ctl) begin
                    bad++;
                    $display("FAIL hazards[%0d] ctl: got %b want %b", i, ctl_obs, got.ctl);
                end
                total++;
                if (stall_cnt !== got.stall) begin
                    bad++;
                    $display("FAIL hazards[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, got.stall);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_halt_drain();
        stim_t st[9] = '{7'b0_000_000, 7'b1_100_101, 7'b1_101_000, 7'b1_100_000,
                         7'b1_100_000, 7'b1_111_011, 7'b1_000_000, 7'b0_100_000,
                         7'b1_100_000};
        exp_t  ex[9] = '{SKIP, want(C_HACC, 0), want(C_DRAIN, 0), want(C_DRAIN, 0),
                         want(C_HALTED, 0), want(C_HALTED, 0), want(C_HALTED, 0),
                         SKIP, want(C_RUN, 0)};
        exp_t  got;
        for (int i = 0; i < 9; i++) begin
            drive(st[i], ex[i]);
            got = sb.pop_front();
            if (got.chk) begin
                total++;
                if (ctl_obs !== got.ctl) begin
                    bad++;
                    $display("FAIL halt_drain[%0d] ctl: got %b want %b", i, ctl_obs, got.ctl);
                end
                total++;
                if (stall_cnt !== got.stall) begin
                    bad++;
                    $display("FAIL halt_drain[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, got.stall);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_in_wait();
        stim_t st[6] = '{7'b0_000_000, 7'b1_101_000, 7'b1_001_000, 7'b0_011_000,
                         7'b1_011_000, 7'b1_101_000};
        exp_t  ex[6] = '{SKIP, want(C_REQ, 0), want(C_REQ, 1), SKIP,
                         want(C_REQ, 0), want(C_RUN, 1)};
        exp_t  got;
        for (int i = 0; i < 6; i++) begin
            drive(st[i], ex[i]);
            got = sb.pop_front();
            if (got.chk) begin
                total++;
                if (ctl_obs !== got.ctl) begin
                    bad++;
                    $display("FAIL reset_in_wait[%0d] ctl: got %b want %b", i, ctl_obs, got.ctl);
                end
                total++;
                if (stall_cnt !== got.stall) begin
                    bad++;
                    $display("FAIL reset_in_wait[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, got.stall);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        nRST     = 1'b0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        dreq     = 1'b0;
        load_use = 1'b0;
        redirect = 1'b0;
        halt_mem = 1'b0;

        test_reset();
        test_run_stream();
        test_wait_d();
        test_wait_i();
        test_hazards();
        test_halt_drain();
        test_reset_in_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the scenarios are fixed-length, so this only trips if the
    // run wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
